// File: rtl/rtc_bus_sequencer_pkg.sv
// Shared types and defaults for the RTC multiplexed-bus sequencer.
package rtc_bus_sequencer_pkg;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_A_SETUP  = 4'd1,
        ST_A_STROBE = 4'd2,
        ST_A_HOLD   = 4'd3,
        ST_GAP      = 4'd4,
        ST_D_SETUP  = 4'd5,
        ST_D_STROBE = 4'd6,
        ST_D_HOLD   = 4'd7,
        ST_DONE     = 4'd8
    } rtc_state_e;

    localparam int unsigned T_SETUP_DEF = 2;
    localparam int unsigned T_PULSE_DEF = 6;
    localparam int unsigned T_HOLD_DEF  = 2;
    localparam int unsigned T_GAP_DEF   = 4;

    // Bus cycle is a fixed linear walk; read/write only changes what each phase drives.
    function automatic rtc_state_e next_phase(input rtc_state_e s);
        case (s)
            ST_IDLE:     return ST_A_SETUP;
            ST_A_SETUP:  return ST_A_STROBE;
            ST_A_STROBE: return ST_A_HOLD;
            ST_A_HOLD:   return ST_GAP;
            ST_GAP:      return ST_D_SETUP;
            ST_D_SETUP:  return ST_D_STROBE;
            ST_D_STROBE: return ST_D_HOLD;
            ST_D_HOLD:   return ST_DONE;
            default:     return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/rtc_bus_sequencer_if.sv
// Request/response and pad-side signals of the RTC bus sequencer.
// master = micro-side requester and pad model; slave = the sequencer.
interface rtc_bus_sequencer_if;
    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       cs_n;
    logic       ad;
    logic       rd_n;
    logic       wr_n;
    logic [7:0] bus_out;
    logic       bus_oe;
    logic [7:0] bus_in;

    modport master (
        output start, rw, addr, wdata, bus_in,
        input  busy, done, rdata, cs_n, ad, rd_n, wr_n, bus_out, bus_oe
    );

    modport slave (
        input  start, rw, addr, wdata, bus_in,
        output busy, done, rdata, cs_n, ad, rd_n, wr_n, bus_out, bus_oe
    );
endinterface

// File: rtl/rtc_bus_sequencer_phase_timer.sv
// Phase timer: 8-bit loadable down-counter, expire when it reads zero.
// Latency: load takes effect at the loading edge; expire is a decode of the register.
// Backpressure: none; holds at zero until reloaded.
module rtc_phase_timer (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    output logic       o_expire
);

    logic [7:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= 8'd0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != 8'd0) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign o_expire = (r_cnt == 8'd0);

endmodule

// File: rtl/rtc_bus_sequencer.sv
// Sequencer for one multiplexed address/data bus cycle to the external RTC chip.
// Latency: done registered 1+2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP cycles after the start edge.
// Backpressure: busy high outside IDLE; starts while busy are dropped, never queued.
module rtc_bus_sequencer
    import rtc_bus_sequencer_pkg::*;
#(
    parameter int unsigned T_SETUP = T_SETUP_DEF,
    parameter int unsigned T_PULSE = T_PULSE_DEF,
    parameter int unsigned T_HOLD  = T_HOLD_DEF,
    parameter int unsigned T_GAP   = T_GAP_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    rtc_bus_sequencer_if.slave    bus
);

    rtc_state_e r_state;
    rtc_state_e w_nxt;
    logic       w_adv;
    logic       w_expire;
    logic [7:0] w_load_val;
    logic [7:0] w_addr;

    logic       r_rw;
    logic [7:0] r_addr;
    logic [7:0] r_wdata;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_rdata;
    logic       r_cs_n;
    logic       r_ad;
    logic       r_rd_n;
    logic       r_wr_n;
    logic [7:0] r_bus_out;
    logic       r_bus_oe;

    function automatic logic [7:0] phase_load(input rtc_state_e s);
        case (s)
            ST_A_SETUP, ST_D_SETUP:   return 8'(T_SETUP - 1);
            ST_A_STROBE, ST_D_STROBE: return 8'(T_PULSE - 1);
            ST_A_HOLD, ST_D_HOLD:     return 8'(T_HOLD - 1);
            ST_GAP:                   return 8'(T_GAP - 1);
            default:                  return 8'd0;
        endcase
    endfunction

    always_comb begin
        w_adv = 1'b0;
        case (r_state)
            ST_IDLE: w_adv = bus.start;
            ST_DONE: w_adv = 1'b1;
            default: w_adv = w_expire;
        endcase
        w_nxt      = w_adv ? next_phase(r_state) : r_state;
        w_load_val = phase_load(w_nxt);
        // The accepting edge must drive the new address before it is latched.
        w_addr     = (r_state == ST_IDLE) ? bus.addr : r_addr;
    end

    rtc_phase_timer u_timer (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_load     (w_adv),
        .i_load_val (w_load_val),
        .o_expire   (w_expire)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_rw      <= 1'b0;
            r_addr    <= 8'd0;
            r_wdata   <= 8'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rdata   <= 8'd0;
            r_cs_n    <= 1'b1;
            r_ad      <= 1'b1;
            r_rd_n    <= 1'b1;
            r_wr_n    <= 1'b1;
            r_bus_out <= 8'd0;
            r_bus_oe  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            if (r_state == ST_IDLE && bus.start) begin
                r_rw    <= bus.rw;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
            if (r_state == ST_D_STROBE && w_expire && r_rw) begin
                r_rdata <= bus.bus_in;
            end

            r_busy   <= (w_nxt != ST_IDLE);
            r_done   <= 1'b0;
            r_cs_n   <= 1'b1;
            r_ad     <= 1'b1;
            r_rd_n   <= 1'b1;
            r_wr_n   <= 1'b1;
            r_bus_oe <= 1'b0;

            // Outputs are decoded from the state being entered so they line up with it.
            case (w_nxt)
                ST_A_SETUP, ST_A_HOLD: begin
                    r_cs_n    <= 1'b0;
                    r_ad      <= 1'b0;
                    r_bus_oe  <= 1'b1;
                    r_bus_out <= w_addr;
                end
                ST_A_STROBE: begin
                    r_cs_n    <= 1'b0;
                    r_ad      <= 1'b0;
                    r_bus_oe  <= 1'b1;
                    r_bus_out <= w_addr;
                    r_wr_n    <= 1'b0;
                end
                ST_D_SETUP, ST_D_HOLD: begin
                    r_cs_n   <= 1'b0;
                    r_bus_oe <= ~r_rw;
                    if (!r_rw) r_bus_out <= r_wdata;
                end
                ST_D_STROBE: begin
                    r_cs_n   <= 1'b0;
                    r_bus_oe <= ~r_rw;
                    r_rd_n   <= ~r_rw;
                    r_wr_n   <= r_rw;
                    if (!r_rw) r_bus_out <= r_wdata;
                end
                ST_DONE: begin
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.rdata   = r_rdata;
    assign bus.cs_n    = r_cs_n;
    assign bus.ad      = r_ad;
    assign bus.rd_n    = r_rd_n;
    assign bus.wr_n    = r_wr_n;
    assign bus.bus_out = r_bus_out;
    assign bus.bus_oe  = r_bus_oe;

endmodule

// File: doc/rtc_bus_sequencer.md
Name: rtc_bus_sequencer

Overview:
- Generates the multiplexed address/data bus cycle toward the external real-time-clock chip: CS, AD, RD and WR strobes plus the tri-state data bus.
- Sits between the RTC port-handling logic driven by the micro (upstream) and the bidirectional datRTC pad at top level (downstream).
- Accepts one read or write request per transaction: an 8-bit register address, plus write data for writes.
- Returns the read byte and a one-cycle done pulse.

Parameters:
- T_SETUP, 2: cycles the bus and AD/CS are stable before a strobe falls (1..255).
- T_PULSE, 6: cycles a strobe is held low (1..255).
- T_HOLD, 2: cycles after a strobe rises before the bus is released or changed (1..255).
- T_GAP, 4: cycles CS is high between the address phase and the data phase (1..255).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- rw  in  1  1 = read, 0 = write; latched on an accepted start.
- addr  in  8  RTC register address; latched on an accepted start.
- wdata  in  8  write data; latched on an accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a transaction.
- rdata  out  8  last byte read; holds its value until the next read completes.
- cs_n  out  1  chip select, active low.
- ad  out  1  0 = address phase, 1 = data phase.
- rd_n  out  1  read strobe, active low.
- wr_n  out  1  write strobe, active low.
- bus_out  out  8  value driven onto datRTC.
- bus_oe  out  1  1 = top level drives bus_out onto datRTC; 0 = datRTC is high-Z.
- bus_in  in  8  datRTC pad value.

Behaviour:
- Reset (asynchronous, any state, takes effect immediately): state IDLE, cs_n=1, ad=1, rd_n=1, wr_n=1, bus_oe=0, bus_out=0, busy=0, done=0, rdata=0, phase counter 0.
- All outputs are registered; no combinational path from inputs to outputs.
- IDLE: strobes and cs_n high, ad=1, bus_oe=0. When start=1 at edge k, latch rw/addr/wdata, load the counter, and enter A_SETUP at edge k.
- A_SETUP, T_SETUP cycles: cs_n=0, ad=0, bus_out=addr, bus_oe=1.
- A_STROBE, T_PULSE cycles: as A_SETUP, plus wr_n=0 (address latch).
- A_HOLD, T_HOLD cycles: wr_n=1; address still driven.
- GAP, T_GAP cycles: cs_n=1, ad=1, bus_oe=0.
- D_SETUP, T_SETUP cycles: cs_n=0, ad=1. For a write, bus_out=wdata and bus_oe=1. For a read, bus_oe=0.
- D_STROBE, T_PULSE cycles: rd_n=0 for a read, wr_n=0 for a write. For a read, bus_in is captured into rdata at the edge ending the last strobe cycle.
- D_HOLD, T_HOLD cycles: strobes high. For a write, data is still driven.
- DONE, 1 cycle: cs_n=1, bus_oe=0, done=1, busy=1. Next state is IDLE.
- Latency: with the start edge at k, DONE occupies cycle k+1+2*(T_SETUP+T_PULSE+T_HOLD)+T_GAP. With defaults this is k+25, and busy is high for 25 cycles.
- rd_n and wr_n are never low at the same time.
- bus_oe=0 whenever rd_n=0.
- bus_oe is never 1 while cs_n=1.
- A start while busy (including DONE) is ignored; no queuing.
- A start arriving in the IDLE cycle right after DONE is accepted normally (back-to-back transactions).
- rdata is unchanged by write transactions.
- Phase counter: 8-bit down-counter loaded with N-1 on phase entry. The phase advances when the counter reads 0 and is not decremented further.

Decomposition:
- Shared include rtc_bus_defs: state encodings (IDLE, A_SETUP, A_STROBE, A_HOLD, GAP, D_SETUP, D_STROBE, D_HOLD, DONE; 4 bits) and the default timing constants.
- One sub-module, rtc_phase_timer: 8-bit loadable down-counter with a load input and an expire output. The FSM loads it on every state transition.

Test Plan:
- Write: start with rw=0, addr=8'h21, wdata=8'h5A.
  - Address phase: ad=0, bus_out=21, bus_oe=1, wr_n low for 6 cycles.
  - Data phase: ad=1, bus_out=5A, wr_n low for 6 cycles.
  - done pulses at k+25; rdata stays 0.
- Read: start with rw=1, addr=8'h22; bench drives bus_in=8'hA7 while rd_n=0.
  - bus_oe=0 throughout the data phase.
  - rdata=A7 at done; wr_n stays high in the data phase.
- Busy rejection: a second start at k+5 during a write is ignored.
  - Exactly one done pulse; addr/wdata changes after k have no effect on bus_out.
- Back-to-back: a read issued in the cycle after DONE of a write is accepted.
  - The next done occurs 26 cycles after the first.
  - Strobe-overlap and bus-contention assertions (rd_n/wr_n, bus_oe rules above) hold throughout.
- Async reset: assert reset low mid-way through D_STROBE of a write.
  - Outputs go idle immediately with no clock edge: wr_n=1, cs_n=1, bus_oe=0.
  - After release, a fresh read completes normally.
- Parameter sweep: T_SETUP=T_PULSE=T_HOLD=T_GAP=1.
  - Every phase lasts exactly 1 cycle; done at k+8.
